// File: rtl/hub75_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : hub75_scan_driver
// Description : HUB75 LED-panel scan driver. Fetches top/bottom pixel pairs
//               from a framebuffer port, shifts one row pair per scan line
//               and displays each bit plane for a binary-weighted time (BCM).
// Revision    : 1.0 - initial release
// ============================================================================
module hub75_scan_driver #(
    parameter int COLS    = 32,
    parameter int ROWS    = 32,
    parameter int BPP     = 4,
    parameter int ON_TIME = 8
) (
    input  logic                                              clk,
    input  logic                                              resetn,
    input  logic                                              enable,
    output logic [(((ROWS / 2) > 1) ? $clog2(ROWS / 2) : 1)-1:0] rd_row,
    output logic [$clog2(COLS)-1:0]                           rd_col,
    input  logic [6*BPP-1:0]                                  rd_data,
    output logic                                              PANEL_R0,
    output logic                                              PANEL_G0,
    output logic                                              PANEL_B0,
    output logic                                              PANEL_R1,
    output logic                                              PANEL_G1,
    output logic                                              PANEL_B1,
    output logic                                              PANEL_A,
    output logic                                              PANEL_B,
    output logic                                              PANEL_C,
    output logic                                              PANEL_D,
    output logic                                              PANEL_CLK,
    output logic                                              PANEL_STB,
    output logic                                              PANEL_OE,
    output logic                                              frame_done
);

    localparam int c_scan_rows = ROWS / 2;
    localparam int c_row_w     = (c_scan_rows > 1) ? $clog2(c_scan_rows) : 1;
    localparam int c_col_w     = $clog2(COLS);
    localparam int c_plane_w   = (BPP > 1) ? $clog2(BPP) : 1;
    localparam int c_cnt_w     = $clog2((ON_TIME << (BPP - 1)) + 1);
    localparam int c_idx_w     = $clog2(6 * BPP);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        LATCH   = 2'd2,
        DISPLAY = 2'd3
    } state_t;

    state_t                 r_state;
    logic [c_row_w-1:0]     r_row;
    logic [c_plane_w-1:0]   r_plane;
    logic [c_col_w-1:0]     r_col;
    logic [1:0]             r_phase;
    logic [c_cnt_w-1:0]     r_disp_cnt;

    logic [31:0]            w_disp_len;
    logic                   w_disp_last;
    logic                   w_plane_last;
    logic                   w_row_last;
    logic [c_row_w-1:0]     w_next_row;
    logic [c_plane_w-1:0]   w_next_plane;
    logic [5:0]             w_bits;

    // Plane bookkeeping and selection of the current bit plane from each colour field
    always_comb begin
        w_disp_len   = 32'(ON_TIME) << r_plane;
        w_disp_last  = (32'(r_disp_cnt) == (w_disp_len - 32'd1));
        w_plane_last = (32'(r_plane) == 32'(BPP - 1));
        w_row_last   = (32'(r_row) == 32'(c_scan_rows - 1));
        w_next_row   = r_row;
        w_next_plane = r_plane + c_plane_w'(1);
        if (w_plane_last) begin
            w_next_plane = '0;
            w_next_row   = w_row_last ? '0 : (r_row + c_row_w'(1));
        end
        // bit 5 = R0 field ... bit 0 = B1 field; fields are packed MSB-first
        w_bits = '0;
        for (int f = 0; f < 6; f++) begin
            w_bits[f] = rd_data[c_idx_w'(f * BPP) + c_idx_w'(r_plane)];
        end
    end

    // Scan state machine; every panel and framebuffer output is registered here
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_row      <= '0;
            r_plane    <= '0;
            r_col      <= '0;
            r_phase    <= 2'd0;
            r_disp_cnt <= '0;
            rd_row     <= '0;
            rd_col     <= '0;
            PANEL_R0   <= 1'b0;
            PANEL_G0   <= 1'b0;
            PANEL_B0   <= 1'b0;
            PANEL_R1   <= 1'b0;
            PANEL_G1   <= 1'b0;
            PANEL_B1   <= 1'b0;
            PANEL_A    <= 1'b0;
            PANEL_B    <= 1'b0;
            PANEL_C    <= 1'b0;
            PANEL_D    <= 1'b0;
            PANEL_CLK  <= 1'b0;
            PANEL_STB  <= 1'b0;
            PANEL_OE   <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    PANEL_OE  <= 1'b1;
                    PANEL_CLK <= 1'b0;
                    PANEL_STB <= 1'b0;
                    if (enable) begin
                        r_state <= SHIFT;
                        r_col   <= '0;
                        r_phase <= 2'd0;
                        // Address goes out on entry so the RAM's one-cycle
                        // latency lands in phase 1
                        rd_row  <= r_row;
                        rd_col  <= '0;
                    end
                end
                SHIFT: begin
                    PANEL_OE  <= 1'b1;
                    PANEL_STB <= 1'b0;
                    case (r_phase)
                        2'd0: begin
                            PANEL_CLK <= 1'b0;
                            rd_row    <= r_row;
                            rd_col    <= r_col;
                            r_phase   <= 2'd1;
                        end
                        2'd1: begin
                            PANEL_R0 <= w_bits[5];
                            PANEL_G0 <= w_bits[4];
                            PANEL_B0 <= w_bits[3];
                            PANEL_R1 <= w_bits[2];
                            PANEL_G1 <= w_bits[1];
                            PANEL_B1 <= w_bits[0];
                            r_phase  <= 2'd2;
                        end
                        default: begin
                            PANEL_CLK <= 1'b1;
                            r_phase   <= 2'd0;
                            if (32'(r_col) == 32'(COLS - 1)) begin
                                r_state <= LATCH;
                            end else begin
                                r_col  <= r_col + c_col_w'(1);
                                rd_col <= r_col + c_col_w'(1);
                            end
                        end
                    endcase
                end
                LATCH: begin
                    PANEL_CLK  <= 1'b0;
                    PANEL_STB  <= 1'b1;
                    PANEL_OE   <= 1'b1;
                    {PANEL_D, PANEL_C, PANEL_B, PANEL_A} <= 4'(r_row);
                    r_disp_cnt <= '0;
                    r_state    <= DISPLAY;
                end
                DISPLAY: begin
                    // OE stays low through the last count; the next state's
                    // first cycle raises it, giving exactly ON_TIME<<plane low cycles
                    PANEL_STB <= 1'b0;
                    PANEL_OE  <= 1'b0;
                    if (w_disp_last) begin
                        r_disp_cnt <= '0;
                        r_plane    <= w_next_plane;
                        r_row      <= w_next_row;
                        if (w_plane_last && w_row_last) begin
                            frame_done <= 1'b1;
                        end
                        if (enable) begin
                            r_state <= SHIFT;
                            r_col   <= '0;
                            r_phase <= 2'd0;
                            rd_row  <= w_next_row;
                            rd_col  <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_disp_cnt <= r_disp_cnt + c_cnt_w'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hub75_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_hub75_scan_driver
// Description : Self-checking bench for hub75_scan_driver. Two instances:
//               A (COLS=4, ROWS=8, BPP=2, ON_TIME=2), B (COLS=2, ROWS=8,
//               BPP=1, ON_TIME=1). Expected panel events are queued ahead
//               of time and consumed by a monitor as the DUT emits them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hub75_scan_driver;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // ---------------- instance A ----------------
    logic        resetn_a = 1'b0;
    logic        enable_a = 1'b0;
    logic [1:0]  rd_row_a;
    logic [1:0]  rd_col_a;
    logic [11:0] rd_data_a = '0;
    logic        r0_a, g0_a, b0_a, r1_a, g1_a, b1_a;
    logic        pa_a, pb_a, pc_a, pd_a, pclk_a, stb_a, oe_a, fd_a;

    // ---------------- instance B ----------------
    logic        resetn_b = 1'b0;
    logic        enable_b = 1'b0;
    logic [1:0]  rd_row_b;
    logic [0:0]  rd_col_b;
    logic [5:0]  rd_data_b = '0;
    logic        r0_b, g0_b, b0_b, r1_b, g1_b, b1_b;
    logic        pa_b, pb_b, pc_b, pd_b, pclk_b, stb_b, oe_b, fd_b;

    hub75_scan_driver #(.COLS(4), .ROWS(8), .BPP(2), .ON_TIME(2)) u_dut_a (
        .clk(clk), .resetn(resetn_a), .enable(enable_a),
        .rd_row(rd_row_a), .rd_col(rd_col_a), .rd_data(rd_data_a),
        .PANEL_R0(r0_a), .PANEL_G0(g0_a), .PANEL_B0(b0_a),
        .PANEL_R1(r1_a), .PANEL_G1(g1_a), .PANEL_B1(b1_a),
        .PANEL_A(pa_a), .PANEL_B(pb_a), .PANEL_C(pc_a), .PANEL_D(pd_a),
        .PANEL_CLK(pclk_a), .PANEL_STB(stb_a), .PANEL_OE(oe_a),
        .frame_done(fd_a)
    );

    hub75_scan_driver #(.COLS(2), .ROWS(8), .BPP(1), .ON_TIME(1)) u_dut_b (
        .clk(clk), .resetn(resetn_b), .enable(enable_b),
        .rd_row(rd_row_b), .rd_col(rd_col_b), .rd_data(rd_data_b),
        .PANEL_R0(r0_b), .PANEL_G0(g0_b), .PANEL_B0(b0_b),
        .PANEL_R1(r1_b), .PANEL_G1(g1_b), .PANEL_B1(b1_b),
        .PANEL_A(pa_b), .PANEL_B(pb_b), .PANEL_C(pc_b), .PANEL_D(pd_b),
        .PANEL_CLK(pclk_b), .PANEL_STB(stb_b), .PANEL_OE(oe_b),
        .frame_done(fd_b)
    );

    // Synchronous framebuffer models: data one cycle after the address.
    // A: pixel(r,c) has R0=c, all other fields 0.
    always @(posedge clk) rd_data_a <= {rd_col_a, 10'd0};
    always @(posedge clk) rd_data_b <= {rd_col_b, 3'd0, rd_row_b};

    // Scoreboard queues
    ev_t exp_rise[$];
    ev_t exp_stb[$];
    int  exp_oe[$];
    int  exp_fd[$];
    ev_t exp_b_stb[$];
    int  exp_b_oe[$];
    int  exp_b_fd[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_avail(input string tag, input int n);
        tests++;
        assert (n > 0) else begin
            fails++;
            $error("FAIL %s: observed unexpected event at cycle %0d, expected none pending", tag, cyc);
        end
    endtask

    task automatic push_plane_a(input int s, input int row, input int plane);
        ev_t e;
        for (int i = 0; i < 4; i++) begin
            e.cyc = s - 10 + 3 * i;
            e.val = (i >> plane) & 1;
            exp_rise.push_back(e);
        end
        e.cyc = s;
        e.val = row;
        exp_stb.push_back(e);
        exp_oe.push_back(2 << plane);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Monitor: observe panel events on the falling edge and compare with the queues
    int   run_a = 0;
    int   run_b = 0;
    logic prev_clk_a = 1'b0;
    always @(negedge clk) begin
        ev_t e;
        if (resetn_a) begin
            if (!oe_a) check("oe_guard_a", {30'd0, stb_a, pclk_a}, 32'd0);
            if (pclk_a && !prev_clk_a) begin
                check_avail("rise_a", exp_rise.size());
                if (exp_rise.size() > 0) begin
                    e = exp_rise.pop_front();
                    check("rise_cyc_a", cyc, e.cyc);
                    check("rise_r0_a", {31'd0, r0_a}, e.val);
                    check("rise_others_a", {27'd0, g0_a, b0_a, r1_a, g1_a, b1_a}, 32'd0);
                end
            end
            if (stb_a) begin
                check_avail("stb_a", exp_stb.size());
                if (exp_stb.size() > 0) begin
                    e = exp_stb.pop_front();
                    check("stb_cyc_a", cyc, e.cyc);
                    check("stb_addr_a", {28'd0, pd_a, pc_a, pb_a, pa_a}, e.val);
                    check("stb_rd_row_a", {30'd0, rd_row_a}, e.val);
                end
            end
            if (!oe_a) begin
                run_a++;
            end else if (run_a > 0) begin
                check_avail("oe_run_a", exp_oe.size());
                if (exp_oe.size() > 0) check("oe_low_len_a", run_a, exp_oe.pop_front());
                run_a = 0;
            end
            if (fd_a) begin
                check_avail("fd_a", exp_fd.size());
                if (exp_fd.size() > 0) check("fd_cyc_a", cyc, exp_fd.pop_front());
            end
        end else begin
            run_a = 0;
        end
        prev_clk_a = pclk_a;

        if (resetn_b) begin
            if (!oe_b) check("oe_guard_b", {30'd0, stb_b, pclk_b}, 32'd0);
            if (stb_b) begin
                check_avail("stb_b", exp_b_stb.size());
                if (exp_b_stb.size() > 0) begin
                    e = exp_b_stb.pop_front();
                    check("stb_cyc_b", cyc, e.cyc);
                    check("stb_addr_b", {28'd0, pd_b, pc_b, pb_b, pa_b}, e.val);
                end
            end
            if (!oe_b) begin
                run_b++;
            end else if (run_b > 0) begin
                check_avail("oe_run_b", exp_b_oe.size());
                if (exp_b_oe.size() > 0) check("oe_low_len_b", run_b, exp_b_oe.pop_front());
                run_b = 0;
            end
            if (fd_b) begin
                check_avail("fd_b", exp_b_fd.size());
                if (exp_b_fd.size() > 0) check("fd_cyc_b", cyc, exp_b_fd.pop_front());
            end
        end else begin
            run_b = 0;
        end
    end

    initial begin
        int rel, s, row, plane, s_last, t, rel2, relb;
        ev_t e;

        // Reset held with enable already high: outputs must sit at reset values
        repeat (3) @(negedge clk);
        enable_a = 1'b1;
        @(negedge clk);
        check("rst_oe", {31'd0, oe_a}, 32'd1);
        check("rst_clk", {31'd0, pclk_a}, 32'd0);
        check("rst_stb", {31'd0, stb_a}, 32'd0);
        check("rst_fd", {31'd0, fd_a}, 32'd0);
        check("rst_rgb", {26'd0, r0_a, g0_a, b0_a, r1_a, g1_a, b1_a}, 32'd0);
        check("rst_addr", {28'd0, pd_a, pc_a, pb_a, pa_a}, 32'd0);
        check("rst_rd_row", {30'd0, rd_row_a}, 32'd0);
        check("rst_rd_col", {30'd0, rd_col_a}, 32'd0);

        // Two full frames, then row 0 and row 1 plane 0 of the third frame.
        // Plane period = 3*4 + 1 + (2<<plane): 15 then 17.
        rel    = cyc;
        s      = rel + 14;
        row    = 0;
        plane  = 0;
        s_last = 0;
        for (int k = 0; k < 19; k++) begin
            push_plane_a(s, row, plane);
            if (k == 18) s_last = s;
            if (plane == 1 && row == 3) exp_fd.push_back(s + (2 << plane));
            s = s + 13 + (2 << plane);
            if (plane == 1) begin
                plane = 0;
                row   = (row + 1) % 4;
            end else begin
                plane = 1;
            end
        end
        resetn_a = 1'b1;

        // Drop enable mid-shift of row 1 plane 0; plane completes, then idle
        wait_cyc(s_last - 8);
        enable_a = 1'b0;
        wait_cyc(s_last + 10);
        check("idle_oe", {31'd0, oe_a}, 32'd1);
        check("idle_clk", {31'd0, pclk_a}, 32'd0);
        check("idle_drain", exp_rise.size() + exp_stb.size() + exp_oe.size() + exp_fd.size(), 32'd0);

        // Resume: row 1 plane 1, then row 2 plane 0 (its display cut by reset)
        t = cyc;
        push_plane_a(t + 14, 1, 1);
        push_plane_a(t + 31, 2, 0);
        void'(exp_oe.pop_back());
        enable_a = 1'b1;
        wait_cyc(t + 32);
        check("oe_low_pre_rst", {31'd0, oe_a}, 32'd0);
        #2 resetn_a = 1'b0;
        #1;
        check("oe_async", {31'd0, oe_a}, 32'd1);
        check("stb_async", {31'd0, stb_a}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("rst_drain", exp_rise.size() + exp_stb.size() + exp_oe.size() + exp_fd.size(), 32'd0);

        // After release the first latch must carry address 0, plane 0 data
        rel2 = cyc;
        push_plane_a(rel2 + 14, 0, 0);
        resetn_a = 1'b1;
        wait_cyc(rel2 + 18);
        resetn_a = 1'b0;
        @(negedge clk);
        check("drain_a", exp_rise.size() + exp_stb.size() + exp_oe.size() + exp_fd.size(), 32'd0);

        // Instance B: one plane per row, period 3*2+1+1 = 8, frame every 32
        relb = cyc;
        s    = relb + 8;
        for (int k = 0; k < 8; k++) begin
            e.cyc = s;
            e.val = k % 4;
            exp_b_stb.push_back(e);
            exp_b_oe.push_back(1);
            if (k % 4 == 3) exp_b_fd.push_back(s + 1);
            s = s + 8;
        end
        enable_b = 1'b1;
        resetn_b = 1'b1;
        wait_cyc(relb + 70);
        resetn_b = 1'b0;
        @(negedge clk);
        check("drain_b", exp_b_stb.size() + exp_b_oe.size() + exp_b_fd.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
